forwarding_hazard_unit: RTL and testbench

//  Parametrised forwarding and hazard unit for the ARM pipeline. Tracks in-flight destination

---
 rtl/forwarding_hazard_unit.sv | 128 ++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_hazard_unit.sv
// ----------------------------------------------------------------------------
// forwarding_hazard_unit
//   Forwarding and hazard resolution for the ARM pipeline. A private shadow
//   pipeline of destination tags (EXE..WB) is compared against every ID-stage
//   source. Each source picks its youngest in-flight producer independently.
//   Produces registered EXE bypass selects, a combinational load-use / RAW
//   stall back to ID, and a saturating stall-cycle counter.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous reset, active-high
//   i_advance      pipeline moves this cycle (0 = global freeze)
//   i_flush        squash the ID instruction
//   i_fwd_en       1 = forward, 0 = stall on every RAW hazard
//   i_id_valid     ID holds a real instruction
//   i_id_src       ID source registers, src i at [i*RA_W +: RA_W]
//   i_id_src_used  source i is actually read
//   i_id_wb_en     ID instruction writes i_id_dest
//   i_id_mem_read  ID instruction is a load
//   i_id_dest      ID destination register
//   o_hazard_stall combinational stall: hold PC/IF/ID, bubble into EXE
//   o_sel_src      registered EXE bypass select per source
//                  (0 = regfile, k = value held at position k+1)
//   o_stall_count  saturating count of stall cycles
// ----------------------------------------------------------------------------
module forwarding_hazard_unit #(
   parameter  int unsigned RA_W       = 4,
   parameter  int unsigned NUM_SRC    = 2,
   parameter  int unsigned NUM_STAGES = 3,
   parameter  int unsigned CNT_W      = 16,
   localparam int unsigned SEL_W      = $clog2(NUM_STAGES)
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_advance,
   input  logic                       i_flush,
   input  logic                       i_fwd_en,
   input  logic                       i_id_valid,
   input  logic [NUM_SRC*RA_W-1:0]    i_id_src,
   input  logic [NUM_SRC-1:0]         i_id_src_used,
   input  logic                       i_id_wb_en,
   input  logic                       i_id_mem_read,
   input  logic [RA_W-1:0]            i_id_dest,
   output logic                       o_hazard_stall,
   output logic [NUM_SRC*SEL_W-1:0]   o_sel_src,
   output logic [CNT_W-1:0]           o_stall_count
);

   // Shadow tag pipe; index 1 is the instruction currently in EXE.
   logic                r_tag_wb   [1:NUM_STAGES];
   logic                r_tag_mr   [1:NUM_STAGES];
   logic [RA_W-1:0]     r_tag_dest [1:NUM_STAGES];

   logic [NUM_SRC*SEL_W-1:0] r_sel;
   logic [CNT_W-1:0]         r_cnt;

   logic [NUM_SRC-1:0]  w_hit;
   logic [NUM_SRC-1:0]  w_load_use;
   logic [SEL_W-1:0]    w_k [NUM_SRC];
   logic                w_stall;
   logic                w_bubble;

   // Per-source producer search; scanning oldest to youngest lets the
   // youngest match overwrite. The last position is never matched because
   // the register file write-to-read bypass covers it.
   always_comb begin
      w_hit      = '0;
      w_load_use = '0;
      w_stall    = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_k[i] = '0;
         for (int k = NUM_STAGES - 1; k >= 1; k--) begin
            if (i_id_valid && i_id_src_used[i] && r_tag_wb[k] &&
                (r_tag_dest[k] == i_id_src[i*RA_W +: RA_W])) begin
               w_hit[i] = 1'b1;
               w_k[i]   = SEL_W'(k);
            end
         end
         w_load_use[i] = w_hit[i] && (w_k[i] == SEL_W'(1)) && r_tag_mr[1];
      end
      if (i_id_valid) begin
         w_stall = i_fwd_en ? (|w_load_use) : (|w_hit);
      end
   end

   assign w_bubble = i_flush || w_stall || !i_id_valid;

   // Tag shift, bypass-select capture and stall counting.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 1; k <= NUM_STAGES; k++) begin
            r_tag_wb[k]   <= 1'b0;
            r_tag_mr[k]   <= 1'b0;
            r_tag_dest[k] <= '0;
         end
         r_sel <= '0;
         r_cnt <= '0;
      end else if (i_advance) begin
         for (int k = 2; k <= NUM_STAGES; k++) begin
            r_tag_wb[k]   <= r_tag_wb[k-1];
            r_tag_mr[k]   <= r_tag_mr[k-1];
            r_tag_dest[k] <= r_tag_dest[k-1];
         end
         if (w_bubble) begin
            r_tag_wb[1]   <= 1'b0;
            r_tag_mr[1]   <= 1'b0;
            r_tag_dest[1] <= '0;
            r_sel         <= '0;
         end else begin
            r_tag_wb[1]   <= i_id_wb_en;
            r_tag_mr[1]   <= i_id_mem_read;
            r_tag_dest[1] <= i_id_dest;
            for (int i = 0; i < NUM_SRC; i++) begin
               r_sel[i*SEL_W +: SEL_W] <= i_fwd_en ? w_k[i] : '0;
            end
         end
         // Flushed stalls do not count; counter sticks at all ones.
         if (w_stall && !i_flush && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_hazard_stall = w_stall;
   assign o_sel_src      = r_sel;
   assign o_stall_count  = r_cnt;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_forwarding_hazard_unit
//   Directed vectors for forwarding_hazard_unit. A second instance with a
//   3-bit counter shares all stimulus and exercises counter saturation.
// ----------------------------------------------------------------------------
module tb_forwarding_hazard_unit;

   localparam int unsigned RA_W    = 4;
   localparam int unsigned NUM_SRC = 2;
   localparam int unsigned SEL_W   = 2;
   localparam int unsigned CNT_W   = 16;

   logic                     clk;
   logic                     rst;
   logic                     advance;
   logic                     flush;
   logic                     fwd_en;
   logic                     id_valid;
   logic [NUM_SRC*RA_W-1:0]  id_src;
   logic [NUM_SRC-1:0]       id_src_used;
   logic                     id_wb_en;
   logic                     id_mem_read;
   logic [RA_W-1:0]          id_dest;
   logic                     w_stall;
   logic [NUM_SRC*SEL_W-1:0] w_sel;
   logic [CNT_W-1:0]         w_cnt;
   logic                     w_sat_stall;
   logic [NUM_SRC*SEL_W-1:0] w_sat_sel;
   logic [2:0]               w_sat_cnt;

   int n_chk;
   int n_pass;
   int exp_cnt;

   forwarding_hazard_unit #(.RA_W(RA_W), .NUM_SRC(NUM_SRC), .NUM_STAGES(3), .CNT_W(CNT_W)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_advance(advance), .i_flush(flush), .i_fwd_en(fwd_en),
      .i_id_valid(id_valid), .i_id_src(id_src), .i_id_src_used(id_src_used),
      .i_id_wb_en(id_wb_en), .i_id_mem_read(id_mem_read), .i_id_dest(id_dest),
      .o_hazard_stall(w_stall), .o_sel_src(w_sel), .o_stall_count(w_cnt)
   );

   forwarding_hazard_unit #(.RA_W(RA_W), .NUM_SRC(NUM_SRC), .NUM_STAGES(3), .CNT_W(3)) u_sat (
      .i_clk(clk), .i_rst(rst), .i_advance(advance), .i_flush(flush), .i_fwd_en(fwd_en),
      .i_id_valid(id_valid), .i_id_src(id_src), .i_id_src_used(id_src_used),
      .i_id_wb_en(id_wb_en), .i_id_mem_read(id_mem_read), .i_id_dest(id_dest),
      .o_hazard_stall(w_sat_stall), .o_sel_src(w_sat_sel), .o_stall_count(w_sat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Put an instruction in ID; sources packed as {src1, src0}.
   task automatic set_id(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                         input logic [1:0] used, input logic wb, input logic mr,
                         input logic [3:0] dest);
      id_valid    = v;
      id_src      = {s1, s0};
      id_src_used = used;
      id_wb_en    = wb;
      id_mem_read = mr;
      id_dest     = dest;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      set_id(1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 4'd0);
   endtask

   task automatic drain();
      nop();
      repeat (3) tick();
   endtask

   initial begin
      n_chk = 0; n_pass = 0; exp_cnt = 0;
      rst = 1'b1; advance = 1'b1; flush = 1'b0; fwd_en = 1'b1;
      nop();
      repeat (2) tick();
      chk("reset_sel", 32'(w_sel), 32'd0);
      chk("reset_cnt", 32'(w_cnt), 32'd0);
      rst = 1'b0;

      // 1: reset pulse with r3 in flight drops the tags
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 4'd3); tick();
      set_id(1'b1, 4'd3, 4'd0, 2'b01, 1'b1, 1'b0, 4'd3); tick();
      chk("pre_rst_sel", 32'(w_sel), 32'd1);
      rst = 1'b1; #2; rst = 1'b0; #1;
      chk("rst_sel", 32'(w_sel), 32'd0);
      chk("rst_cnt", 32'(w_cnt), 32'd0);
      set_id(1'b1, 4'd3, 4'd0, 2'b01, 1'b0, 1'b0, 4'd0);
      chk("rst_stall", 32'(w_stall), 32'd0);
      tick();
      chk("rst_consumer_sel", 32'(w_sel), 32'd0);
      drain();

      // 2: EXE forward, MEM forward, unused source
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 4'd3); tick();
      set_id(1'b1, 4'd3, 4'd0, 2'b01, 1'b1, 1'b0, 4'd6);
      chk("alu_stall", 32'(w_stall), 32'd0);
      tick();
      chk("fwd_exe_sel", 32'(w_sel), 32'd1);
      set_id(1'b1, 4'd3, 4'd0, 2'b01, 1'b0, 1'b0, 4'd0); tick();
      chk("fwd_mem_sel", 32'(w_sel), 32'd2);
      drain();
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 4'd3); tick();
      set_id(1'b1, 4'd3, 4'd3, 2'b00, 1'b0, 1'b0, 4'd0); tick();
      chk("unused_sel", 32'(w_sel), 32'd0);
      drain();

      // 3: both sources forward; youngest producer wins
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 4'd3); tick();
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 4'd5); tick();
      set_id(1'b1, 4'd5, 4'd3, 2'b11, 1'b0, 1'b0, 4'd0); tick();
      chk("dual_sel", 32'(w_sel), 32'h9);
      drain();
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 4'd3); tick();
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 4'd3); tick();
      set_id(1'b1, 4'd0, 4'd3, 2'b10, 1'b0, 1'b0, 4'd0); tick();
      chk("youngest_sel", 32'(w_sel), 32'h4);
      drain();

      // 4: load-use, one stall then WB forward on src1
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b1, 4'd4); tick();
      set_id(1'b1, 4'd0, 4'd4, 2'b10, 1'b1, 1'b0, 4'd7);
      chk("lu_stall", 32'(w_stall), 32'd1);
      tick(); exp_cnt++;
      chk("lu_bubble_sel", 32'(w_sel), 32'd0);
      chk("lu_cnt", 32'(w_cnt), 32'(exp_cnt));
      chk("lu_stall_clear", 32'(w_stall), 32'd0);
      tick();
      chk("lu_fwd_sel", 32'(w_sel), 32'h8);
      drain();

      // 5: forwarding disabled, stall until producer reaches WB
      fwd_en = 1'b0;
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 4'd3); tick();
      set_id(1'b1, 4'd3, 4'd0, 2'b01, 1'b0, 1'b0, 4'd0);
      chk("nofwd_stall1", 32'(w_stall), 32'd1);
      tick(); exp_cnt++;
      chk("nofwd_sel1", 32'(w_sel), 32'd0);
      chk("nofwd_stall2", 32'(w_stall), 32'd1);
      tick(); exp_cnt++;
      chk("nofwd_stall3", 32'(w_stall), 32'd0);
      tick();
      chk("nofwd_sel", 32'(w_sel), 32'd0);
      chk("nofwd_cnt", 32'(w_cnt), 32'(exp_cnt));
      fwd_en = 1'b1;
      drain();

      // 6a: freeze during load-use holds everything
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 4'd2); tick();
      set_id(1'b1, 4'd2, 4'd0, 2'b01, 1'b1, 1'b1, 4'd4); tick();
      chk("frz_pre_sel", 32'(w_sel), 32'd1);
      set_id(1'b1, 4'd0, 4'd4, 2'b10, 1'b0, 1'b0, 4'd0);
      advance = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("frz_stall", 32'(w_stall), 32'd1);
         chk("frz_sel", 32'(w_sel), 32'd1);
         chk("frz_cnt", 32'(w_cnt), 32'(exp_cnt));
      end
      advance = 1'b1;
      tick(); exp_cnt++;
      chk("thaw_cnt", 32'(w_cnt), 32'(exp_cnt));
      chk("thaw_sel", 32'(w_sel), 32'd0);
      tick();
      chk("thaw_fwd_sel", 32'(w_sel), 32'h8);
      drain();

      // 6b: flush during stall inserts a bubble and is not counted
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b1, 4'd4); tick();
      set_id(1'b1, 4'd0, 4'd4, 2'b10, 1'b1, 1'b0, 4'd7);
      flush = 1'b1; #1;
      chk("flush_stall", 32'(w_stall), 32'd1);
      tick();
      flush = 1'b0;
      chk("flush_cnt", 32'(w_cnt), 32'(exp_cnt));
      chk("flush_sel", 32'(w_sel), 32'd0);
      set_id(1'b1, 4'd7, 4'd0, 2'b01, 1'b0, 1'b0, 4'd0); tick();
      chk("flush_squashed", 32'(w_sel), 32'd0);
      drain();

      // 6c: repeated load-use stalls; 3-bit counter saturates
      for (int n = 0; n < 5; n++) begin
         set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b1, 4'd4); tick();
         set_id(1'b1, 4'd0, 4'd4, 2'b10, 1'b0, 1'b0, 4'd0); tick(); exp_cnt++;
         tick();
         chk("sat_main_cnt", 32'(w_cnt), 32'(exp_cnt));
         chk("sat_cnt", 32'(w_sat_cnt), (exp_cnt > 7) ? 32'd7 : 32'(exp_cnt));
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
